// File: rtl/hex_display_scheduler.sv
// hex_display_scheduler
// Shares the HEX_0 (time) and HEX_1 (score) PIO slaves between two requesters.
// A granted value is saturated to 9999, converted to BCD by iterative
// double-dabble, encoded to four 7-segment bytes and written with one
// Avalon-MM write to the matching PIO, followed by a one-cycle ack.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   time_req/time_value/time_ack    HEX_0 requester (level req, ack pulse)
//   score_req/score_value/score_ack HEX_1 requester (level req, ack pulse)
//   blank_lz                        blank leading zero digits (units always shown)
//   avm_address                     PIO register address (always 0)
//   avm_write_n                     active-low write strobe
//   avm_writedata                   {d3,d2,d1,d0} segment bytes, d0 = units
//   hex0_chipselect/hex1_chipselect PIO selects
//   busy                            high whenever not idle
module hex_display_scheduler #(
    parameter int unsigned VALUE_W     = 14,
    parameter bit          ACTIVE_LOW  = 1'b1,
    parameter int unsigned CONV_CYCLES = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               time_req,
    input  logic [VALUE_W-1:0] time_value,
    output logic               time_ack,
    input  logic               score_req,
    input  logic [VALUE_W-1:0] score_value,
    output logic               score_ack,
    input  logic               blank_lz,
    output logic [1:0]         avm_address,
    output logic               avm_write_n,
    output logic [31:0]        avm_writedata,
    output logic               hex0_chipselect,
    output logic               hex1_chipselect,
    output logic               busy
);
    localparam int unsigned BCD_W = 16;
    localparam int unsigned SR_W  = BCD_W + VALUE_W;
    localparam int unsigned CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam logic [VALUE_W-1:0] MAX_VAL  = VALUE_W'(9999);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(CONV_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_ENC,
        S_WRITE,
        S_ACK
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_prefer_score;
    logic               r_tgt_score;
    logic [SR_W-1:0]    r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_write_n;
    logic               r_cs0;
    logic               r_cs1;
    logic               r_time_ack;
    logic               r_score_ack;
    logic               r_busy;
    logic [31:0]        r_writedata;

    logic               w_any_req;
    logic               w_grant_score;
    logic [VALUE_W-1:0] w_grant_value;
    logic [VALUE_W-1:0] w_sat_value;
    logic [SR_W-1:0]    w_adj;
    logic [BCD_W-1:0]   w_digits;
    logic [3:0]         w_blank;
    logic [31:0]        w_word;

    // gfedcba pattern for one BCD digit
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    // Full output byte: blanked digits are dark, polarity applied last
    function automatic logic [7:0] enc_byte(input logic [3:0] d, input logic blank);
        logic [7:0] b;
        b = blank ? 8'h00 : {1'b0, seg7(d)};
        enc_byte = ACTIVE_LOW ? ~b : b;
    endfunction

    // Arbitration: lone request wins, otherwise the one not served last
    always_comb begin
        w_any_req     = time_req | score_req;
        w_grant_score = score_req & (~time_req | r_prefer_score);
        w_grant_value = w_grant_score ? score_value : time_value;
        w_sat_value   = (w_grant_value > MAX_VAL) ? MAX_VAL : w_grant_value;
    end

    // Add-3 correction on every BCD digit ahead of the shift
    always_comb begin
        w_adj = r_shift;
        for (int i = 0; i < 4; i++) begin
            if (r_shift[VALUE_W + 4*i +: 4] >= 4'd5) begin
                w_adj[VALUE_W + 4*i +: 4] = r_shift[VALUE_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    // Segment encoding with left-to-right leading-zero blanking
    always_comb begin
        w_digits   = r_shift[SR_W-1 -: BCD_W];
        w_blank[3] = blank_lz & (w_digits[15:12] == 4'd0);
        w_blank[2] = w_blank[3] & (w_digits[11:8] == 4'd0);
        w_blank[1] = w_blank[2] & (w_digits[7:4] == 4'd0);
        w_blank[0] = 1'b0;
        w_word     = '0;
        for (int i = 0; i < 4; i++) begin
            w_word[8*i +: 8] = enc_byte(w_digits[4*i +: 4], w_blank[i]);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_next = S_CONV;
            S_CONV:  if (r_cnt == LAST_CNT) w_next = S_ENC;
            S_ENC:   w_next = S_WRITE;
            S_WRITE: w_next = S_ACK;
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Grant latch and double-dabble shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prefer_score <= 1'b0;
            r_tgt_score    <= 1'b0;
            r_shift        <= '0;
            r_cnt          <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_tgt_score    <= w_grant_score;
                        r_prefer_score <= ~w_grant_score;
                        r_shift        <= {BCD_W'(0), w_sat_value};
                        r_cnt          <= '0;
                    end
                end
                S_CONV: begin
                    r_shift <= w_adj << 1;
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Registered bus outputs, decoded from the upcoming state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_write_n   <= 1'b1;
            r_cs0       <= 1'b0;
            r_cs1       <= 1'b0;
            r_time_ack  <= 1'b0;
            r_score_ack <= 1'b0;
            r_busy      <= 1'b0;
            r_writedata <= '0;
        end else begin
            r_write_n   <= (w_next != S_WRITE);
            r_cs0       <= (w_next == S_WRITE) & ~r_tgt_score;
            r_cs1       <= (w_next == S_WRITE) & r_tgt_score;
            r_time_ack  <= (w_next == S_ACK) & ~r_tgt_score;
            r_score_ack <= (w_next == S_ACK) & r_tgt_score;
            r_busy      <= (w_next != S_IDLE);
            if (r_state == S_ENC) begin
                r_writedata <= w_word;
            end
        end
    end

    assign avm_address     = 2'b00;
    assign avm_write_n     = r_write_n;
    assign avm_writedata   = r_writedata;
    assign hex0_chipselect = r_cs0;
    assign hex1_chipselect = r_cs1;
    assign time_ack        = r_time_ack;
    assign score_ack       = r_score_ack;
    assign busy            = r_busy;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Testbench for hex_display_scheduler: scoreboard of expected PIO writes,
// one task per scenario, plus a second instance with active-high segments.
module tb_hex_display_scheduler;
    localparam int unsigned VALUE_W = 14;

    typedef struct {
        bit          tgt;   // 0 = HEX_0 (time), 1 = HEX_1 (score)
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    bit   m_prefer_score = 0;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               time_req = 1'b0;
    logic [VALUE_W-1:0] time_value = '0;
    logic               time_ack;
    logic               score_req = 1'b0;
    logic [VALUE_W-1:0] score_value = '0;
    logic               score_ack;
    logic               blank_lz = 1'b0;
    logic [1:0]         avm_address;
    logic               avm_write_n;
    logic [31:0]        avm_writedata;
    logic               hex0_cs;
    logic               hex1_cs;
    logic               busy;

    logic               ah_time_req = 1'b0;
    logic [VALUE_W-1:0] ah_time_value = '0;
    logic               ah_time_ack;
    logic               ah_score_ack;
    logic [1:0]         ah_address;
    logic               ah_write_n;
    logic [31:0]        ah_writedata;
    logic               ah_cs0;
    logic               ah_cs1;
    logic               ah_busy;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hex_display_scheduler #(.VALUE_W(VALUE_W), .ACTIVE_LOW(1'b1), .CONV_CYCLES(14)) u_dut (
        .clk(clk), .reset(reset),
        .time_req(time_req), .time_value(time_value), .time_ack(time_ack),
        .score_req(score_req), .score_value(score_value), .score_ack(score_ack),
        .blank_lz(blank_lz), .avm_address(avm_address), .avm_write_n(avm_write_n),
        .avm_writedata(avm_writedata), .hex0_chipselect(hex0_cs),
        .hex1_chipselect(hex1_cs), .busy(busy)
    );

    hex_display_scheduler #(.VALUE_W(VALUE_W), .ACTIVE_LOW(1'b0), .CONV_CYCLES(14)) u_dut_ah (
        .clk(clk), .reset(reset),
        .time_req(ah_time_req), .time_value(ah_time_value), .time_ack(ah_time_ack),
        .score_req(1'b0), .score_value('0), .score_ack(ah_score_ack),
        .blank_lz(1'b0), .avm_address(ah_address), .avm_write_n(ah_write_n),
        .avm_writedata(ah_writedata), .hex0_chipselect(ah_cs0),
        .hex1_chipselect(ah_cs1), .busy(ah_busy)
    );

    function automatic logic [7:0] seg(input int d);
        case (d)
            0: seg = 8'h3F;  1: seg = 8'h06;  2: seg = 8'h5B;  3: seg = 8'h4F;
            4: seg = 8'h66;  5: seg = 8'h6D;  6: seg = 8'h7D;  7: seg = 8'h07;
            8: seg = 8'h7F;  9: seg = 8'h6F;  default: seg = 8'h00;
        endcase
    endfunction

    // Reference word built with integer division, independent of double-dabble
    function automatic logic [31:0] exp_word(input int value, input bit blank, input bit al);
        int          v;
        int          dg[4];
        bit          bl[4];
        logic [31:0] w;
        logic [7:0]  b;
        v     = (value > 9999) ? 9999 : value;
        dg[0] = v % 10;
        dg[1] = (v / 10) % 10;
        dg[2] = (v / 100) % 10;
        dg[3] = v / 1000;
        bl[3] = blank && (dg[3] == 0);
        bl[2] = bl[3] && (dg[2] == 0);
        bl[1] = bl[2] && (dg[1] == 0);
        bl[0] = 1'b0;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            b = bl[i] ? 8'h00 : seg(dg[i]);
            if (al) b = ~b;
            w[8*i +: 8] = b;
        end
        return w;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; time_req = 1'b0; score_req = 1'b0; ah_time_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_prefer_score = 0;
    endtask

    // One lone request: push expectation, wait for the write, check it and the ack
    task automatic do_transaction(input bit tgt, input int value, input bit blank);
        exp_t e;
        exp_t got;
        int   k;
        bit   seen;
        e.tgt  = tgt;
        e.data = exp_word(value, blank, 1'b1);
        @(negedge clk);
        blank_lz = blank;
        if (!tgt) begin time_value = VALUE_W'(value); time_req = 1'b1; end
        else      begin score_value = VALUE_W'(value); score_req = 1'b1; end
        sb_q.push_back(e);
        m_prefer_score = !tgt;
        k = 0; seen = 0;
        while (!seen && k < 40) begin
            @(negedge clk); k++;
            if (avm_write_n === 1'b0) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            $display("FAIL write_timeout tgt=%0d value=%0d: no write within %0d cycles", tgt, value, k);
            sb_q.delete();
            time_req = 1'b0; score_req = 1'b0;
            return;
        end
        n_pass++;
        got = sb_q.pop_front();
        n_checks++;
        if (k !== 16) $display("FAIL write_latency value=%0d: got %0d cycles, want 16", value, k);
        else n_pass++;
        n_checks++;
        if (avm_writedata !== got.data) $display("FAIL writedata value=%0d blank=%0d: got %h, want %h", value, blank, avm_writedata, got.data);
        else n_pass++;
        n_checks++;
        if ({hex1_cs, hex0_cs} !== (got.tgt ? 2'b10 : 2'b01)) $display("FAIL chipselect value=%0d: got cs1,cs0=%b%b, want tgt %0d only", value, hex1_cs, hex0_cs, got.tgt);
        else n_pass++;
        n_checks++;
        if (avm_address !== 2'b00) $display("FAIL address: got %0d, want 0", avm_address);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({avm_write_n, hex1_cs, hex0_cs, score_ack, time_ack} !== {3'b100, tgt, !tgt})
            $display("FAIL ack_cycle value=%0d: got wn,cs1,cs0,sack,tack=%b%b%b%b%b, want 100%b%b", value, avm_write_n, hex1_cs, hex0_cs, score_ack, time_ack, tgt, !tgt);
        else n_pass++;
        time_req = 1'b0; score_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, score_ack, time_ack} !== 3'b000) $display("FAIL after_ack: got busy,sack,tack=%b%b%b, want 000", busy, score_ack, time_ack);
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({busy, avm_write_n, hex0_cs, hex1_cs, time_ack, score_ack, avm_address} !== 8'b01000000)
            $display("FAIL reset_ctrl: got busy,wn,cs0,cs1,tack,sack,addr=%b%b%b%b%b%b%b", busy, avm_write_n, hex0_cs, hex1_cs, time_ack, score_ack, avm_address);
        else n_pass++;
        n_checks++;
        if (avm_writedata !== 32'h0) $display("FAIL reset_data: got %h, want 00000000", avm_writedata);
        else n_pass++;
    endtask

    task automatic test_time_1234();
        do_transaction(1'b0, 1234, 1'b0);
    endtask

    task automatic test_score_blank();
        do_transaction(1'b1, 7, 1'b1);
        do_transaction(1'b1, 0, 1'b1);
    endtask

    task automatic test_saturate_zero();
        do_transaction(1'b0, 12000, 1'b0);
        do_transaction(1'b0, 0, 1'b0);
    endtask

    // Both requests held: grants must alternate, each write 18 cycles apart
    task automatic test_back_to_back();
        exp_t e;
        exp_t got;
        int   k;
        int   last_cyc;
        int   stray;
        bit   seen;
        do_reset();
        @(negedge clk);
        time_value = VALUE_W'(1234); score_value = VALUE_W'(56); blank_lz = 1'b0;
        time_req = 1'b1; score_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e.tgt  = m_prefer_score;
            e.data = exp_word(e.tgt ? 56 : 1234, 1'b0, 1'b1);
            sb_q.push_back(e);
            m_prefer_score = !e.tgt;
        end
        last_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            k = 0; seen = 0;
            while (!seen && k < 40) begin
                @(negedge clk); k++;
                if (avm_write_n === 1'b0) seen = 1;
            end
            n_checks++;
            if (!seen) begin
                $display("FAIL b2b_timeout write %0d: none within %0d cycles", i, k);
                break;
            end
            n_pass++;
            got = sb_q.pop_front();
            if (i > 0) begin
                n_checks++;
                if (cyc - last_cyc !== 18) $display("FAIL b2b_spacing write %0d: got %0d cycles, want 18", i, cyc - last_cyc);
                else n_pass++;
            end
            last_cyc = cyc;
            n_checks++;
            if ({hex1_cs, hex0_cs} !== (got.tgt ? 2'b10 : 2'b01)) $display("FAIL b2b_order write %0d: got cs1,cs0=%b%b, want tgt %0d", i, hex1_cs, hex0_cs, got.tgt);
            else n_pass++;
            n_checks++;
            if (avm_writedata !== got.data) $display("FAIL b2b_data write %0d: got %h, want %h", i, avm_writedata, got.data);
            else n_pass++;
        end
        @(negedge clk);
        time_req = 1'b0; score_req = 1'b0;
        sb_q.delete();
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            if (avm_write_n === 1'b0) stray++;
        end
        n_checks++;
        if (stray !== 0) $display("FAIL b2b_release: got %0d extra write cycles, want 0", stray);
        else n_pass++;
    endtask

    // Reset during CONV aborts the transfer with no write and no ack
    task automatic test_reset_mid();
        int stray;
        @(negedge clk);
        time_value = VALUE_W'(4321); blank_lz = 1'b0; time_req = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL mid_busy: got %b, want 1 during conversion", busy);
        else n_pass++;
        reset = 1'b1; time_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, avm_write_n, hex0_cs, hex1_cs, time_ack, score_ack} !== 6'b010000)
            $display("FAIL mid_reset: got busy,wn,cs0,cs1,tack,sack=%b%b%b%b%b%b, want 010000", busy, avm_write_n, hex0_cs, hex1_cs, time_ack, score_ack);
        else n_pass++;
        reset = 1'b0;
        m_prefer_score = 0;
        stray = 0;
        repeat (25) begin
            @(negedge clk);
            if (avm_write_n === 1'b0 || time_ack === 1'b1 || score_ack === 1'b1) stray++;
        end
        n_checks++;
        if (stray !== 0) $display("FAIL mid_discard: got %0d write/ack cycles, want 0", stray);
        else n_pass++;
        do_transaction(1'b0, 4321, 1'b0);
    endtask

    task automatic test_active_high();
        int          k;
        bit          seen;
        logic [31:0] want;
        want = exp_word(1234, 1'b0, 1'b0);
        @(negedge clk);
        ah_time_value = VALUE_W'(1234); ah_time_req = 1'b1;
        k = 0; seen = 0;
        while (!seen && k < 40) begin
            @(negedge clk); k++;
            if (ah_write_n === 1'b0) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            $display("FAIL ah_timeout: no write within %0d cycles", k);
            ah_time_req = 1'b0;
            return;
        end
        n_pass++;
        n_checks++;
        if (ah_writedata !== want) $display("FAIL ah_writedata: got %h, want %h", ah_writedata, want);
        else n_pass++;
        n_checks++;
        if ({ah_cs1, ah_cs0} !== 2'b01) $display("FAIL ah_chipselect: got cs1,cs0=%b%b, want 01", ah_cs1, ah_cs0);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (ah_time_ack !== 1'b1) $display("FAIL ah_ack: got %b, want 1", ah_time_ack);
        else n_pass++;
        ah_time_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_time_1234();
        test_score_blank();
        test_saturate_zero();
        test_back_to_back();
        test_reset_mid();
        test_active_high();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
